// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : Program counter sequencing and instruction-fetch handshake for
//            the single-issue core. Next-PC priority: reset, redirect, halt,
//            stall, sequential. Squashes in-flight fetches on redirect and
//            parks the core on HLT until reset.
//            Optional macro PC_FETCH_CTRL_PERF_EN adds stall/drain counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int          PC_W      = 16       // fixed at 16 for this core
) (
    input  logic            clk,
    input  logic            rst,          // synchronous, active-low
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            hlt_req,
    input  logic            imem_rdy,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2,
`ifdef PC_FETCH_CTRL_PERF_EN
    output logic [15:0]     stall_cycles,
    output logic [15:0]     drain_cycles,
`endif
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] c_pc_step = PC_W'(2);

    state_t          r_state;
    state_t          w_state_nx;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nx;
    logic            w_in_fetch;
    logic            w_unused_redirect_lsb;

    // Instructions are halfword aligned, so the redirect LSB carries no
    // information and is dropped when the target is loaded.
    assign w_unused_redirect_lsb = redirect_pc[0];

    // Combinational handshake and PC views.
    assign w_in_fetch  = (r_state == ST_FETCH);
    assign imem_req    = rst & w_in_fetch;
    assign instr_valid = rst & w_in_fetch & imem_rdy & ~stall & ~redirect;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign pc_plus2    = r_pc + c_pc_step;
    assign halted      = (r_state == ST_HALTED);

    // State and PC register; reset returns to FETCH at the reset vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_VEC[PC_W-1:0];
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        case (r_state)
            ST_FETCH: begin
                if (redirect) begin
                    // A pending fetch (rdy low) must still be absorbed before
                    // a new request can be issued, hence DRAIN.
                    w_pc_nx    = {redirect_pc[PC_W-1:1], 1'b0};
                    w_state_nx = imem_rdy ? ST_FETCH : ST_DRAIN;
                end else if (instr_valid && hlt_req) begin
                    w_state_nx = ST_HALTED;
                end else if (instr_valid) begin
                    w_pc_nx = r_pc + c_pc_step;
                end
            end
            ST_DRAIN: begin
                if (imem_rdy) begin
                    w_state_nx = ST_FETCH;
                end
            end
            ST_HALTED: begin
                w_state_nx = ST_HALTED;
            end
            default: begin
                w_state_nx = ST_FETCH;
            end
        endcase
    end

`ifdef PC_FETCH_CTRL_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_drain_cycles;

    // Saturating performance counters; HALTED matches neither condition so
    // both counters freeze there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= 16'h0000;
            r_drain_cycles <= 16'h0000;
        end else begin
            if (w_in_fetch && imem_req && !instr_valid && !redirect &&
                (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if ((r_state == ST_DRAIN) && (r_drain_cycles != 16'hFFFF)) begin
                r_drain_cycles <= r_drain_cycles + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign drain_cycles = r_drain_cycles;
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Brief    : Directed self-checking bench for pc_fetch_ctrl. Counter checks
//            are included when PC_FETCH_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        hlt_req;
    logic        imem_rdy;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        halted;
`ifdef PC_FETCH_CTRL_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] drain_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt_req     (hlt_req),
        .imem_rdy    (imem_rdy),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus2    (pc_plus2),
`ifdef PC_FETCH_CTRL_PERF_EN
        .stall_cycles(stall_cycles),
        .drain_cycles(drain_cycles),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        hlt_req = 1'b0; imem_rdy = 1'b1;
        settle();
        chk("rst_req_low", {15'd0, imem_req}, 16'd0);
        chk("rst_iv_low", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_req_low2", {15'd0, imem_req}, 16'd0);

        // Sequential fetch
        rst = 1'b1; settle();
        chk("seq_pc0", pc_out, 16'h0000);
        chk("seq_iv0", {15'd0, instr_valid}, 16'd1);
        chk("seq_req0", {15'd0, imem_req}, 16'd1);
        chk("seq_addr0", imem_addr, 16'h0000);
        chk("seq_plus2_0", pc_plus2, 16'h0002);
        tick();
        chk("seq_pc2", pc_out, 16'h0002);
        chk("seq_iv2", {15'd0, instr_valid}, 16'd1);
        tick();
        chk("seq_pc4", pc_out, 16'h0004);
        tick();
        chk("seq_pc6", pc_out, 16'h0006);

        // Stall three cycles at 0006
        stall = 1'b1; settle();
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", pc_out, 16'h0006);
            chk("stall_iv", {15'd0, instr_valid}, 16'd0);
            chk("stall_req", {15'd0, imem_req}, 16'd1);
            tick();
        end
        stall = 1'b0; settle();
        chk("unstall_pc", pc_out, 16'h0006);
        chk("unstall_iv", {15'd0, instr_valid}, 16'd1);
        tick();
        chk("unstall_pc8", pc_out, 16'h0008);

        // Redirect with outstanding fetch -> DRAIN
        imem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 16'h1235; settle();
        chk("redir_iv", {15'd0, instr_valid}, 16'd0);
        tick();
        // Redirect during DRAIN must be ignored
        redirect = 1'b1; redirect_pc = 16'h4444; settle();
        chk("drain_pc", pc_out, 16'h1234);
        chk("drain_req", {15'd0, imem_req}, 16'd0);
        chk("drain_iv", {15'd0, instr_valid}, 16'd0);
        tick();
        redirect = 1'b0; imem_rdy = 1'b1; settle();
        chk("drain2_pc", pc_out, 16'h1234);
        chk("drain2_req", {15'd0, imem_req}, 16'd0);
        tick();
        imem_rdy = 1'b0; settle();
        chk("refetch_req", {15'd0, imem_req}, 16'd1);
        chk("refetch_addr", imem_addr, 16'h1234);
        chk("refetch_iv", {15'd0, instr_valid}, 16'd0);

        // Wrap: redirect to FFFE with rdy high stays in FETCH
        imem_rdy = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE; settle();
        chk("wrap_redir_iv", {15'd0, instr_valid}, 16'd0);
        tick();
        redirect = 1'b0; settle();
        chk("wrap_pc", pc_out, 16'hFFFE);
        chk("wrap_plus2", pc_plus2, 16'h0000);
        chk("wrap_iv", {15'd0, instr_valid}, 16'd1);
        tick();
        chk("wrap_pc0", pc_out, 16'h0000);
        chk("wrap_plus2_0", pc_plus2, 16'h0002);
        for (int i = 0; i < 8; i++) tick();
        chk("pre_hlt_pc", pc_out, 16'h0010);

        // Stall blocks HLT acceptance
        stall = 1'b1; hlt_req = 1'b1; tick();
        chk("stall_hlt_pc", pc_out, 16'h0010);
        chk("stall_hlt_halted", {15'd0, halted}, 16'd0);
        // Redirect to current pc beats HLT
        stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010; tick();
        chk("redir_hlt_pc", pc_out, 16'h0010);
        chk("redir_hlt_halted", {15'd0, halted}, 16'd0);
        redirect = 1'b0; settle();
        chk("hlt_accept_iv", {15'd0, instr_valid}, 16'd1);
        tick();
        chk("halted", {15'd0, halted}, 16'd1);
        chk("halted_pc", pc_out, 16'h0010);

        // HALTED ignores everything for 20 cycles
        for (int i = 0; i < 20; i++) begin
            redirect = i[0]; stall = i[1]; hlt_req = i[2]; imem_rdy = ~i[0];
            redirect_pc = 16'h2000; settle();
            chk("park_req", {15'd0, imem_req}, 16'd0);
            chk("park_iv", {15'd0, instr_valid}, 16'd0);
            tick();
            chk("park_pc", pc_out, 16'h0010);
            chk("park_halted", {15'd0, halted}, 16'd1);
        end
        redirect = 1'b0; stall = 1'b0; hlt_req = 1'b0; imem_rdy = 1'b0;

        rst = 1'b0; tick();
        chk("unpark_pc", pc_out, 16'h0000);
        chk("unpark_halted", {15'd0, halted}, 16'd0);
        chk("unpark_req", {15'd0, imem_req}, 16'd0);
`ifdef PC_FETCH_CTRL_PERF_EN
        chk("perf_rst_stall", stall_cycles, 16'd0);
        chk("perf_rst_drain", drain_cycles, 16'd0);
`endif

        // Five FETCH cycles with memory not ready
        rst = 1'b1; imem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("wait_pc", pc_out, 16'h0000);
`ifdef PC_FETCH_CTRL_PERF_EN
        chk("perf_stall5", stall_cycles, 16'd5);
`endif
        redirect = 1'b1; redirect_pc = 16'h0100; tick();
        redirect = 1'b0; tick();
        imem_rdy = 1'b1; tick();
        chk("drain_done_pc", pc_out, 16'h0100);
        imem_rdy = 1'b0; settle();
        chk("drain_done_req", {15'd0, imem_req}, 16'd1);
`ifdef PC_FETCH_CTRL_PERF_EN
        chk("perf_drain2", drain_cycles, 16'd2);
        chk("perf_stall_hold", stall_cycles, 16'd5);
        rst = 1'b0; tick();
        chk("perf_clr_stall", stall_cycles, 16'd0);
        chk("perf_clr_drain", drain_cycles, 16'd0);
        rst = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the 16-bit program counter register and the instruction-memory fetch handshake for the single-issue core.
- Sits between the PC register, instruction memory and decode/hazard logic.
- Picks the next PC each cycle from these sources, in priority order: reset, redirect, halt, stall, sequential.
- Squashes in-flight fetches on a redirect.
- Parks the core permanently on HLT.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- PC_W, 16, PC/address width; the core is fixed at 16, and other values are unsupported.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low: sampled only at the rising edge of clk; rst=0 resets the block.
- stall  in  1  hazard back-pressure from decode; 1 = do not accept the current instruction.
- redirect  in  1  taken branch/B/BR/CALL resolved this cycle.
- redirect_pc  in  16  redirect target; bit 0 ignored (forced 0).
- hlt_req  in  1  decode saw HLT; qualified by instr_valid.
- imem_rdy  in  1  instruction memory: data valid for imem_addr.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; equals pc_out.
- instr_valid  out  1  instruction on the memory bus is accepted this cycle.
- pc_out  out  16  current PC.
- pc_plus2  out  16  pc_out+2 (for CALL/PCS).
- halted  out  1  core parked.

Behaviour:
- State register, 3 states: FETCH, DRAIN, HALTED. PC register is 16 bits.
- Reset (rst=0 at an edge, from any state, including mid-fetch or DRAIN):
  - Next cycle: pc_out=RESET_VEC, state=FETCH, halted=0.
  - While rst=0: imem_req=0 and instr_valid=0.
- Memory protocol:
  - imem_req stays high with imem_addr stable until the fetch is accepted or squashed.
  - Memory holds imem_rdy and its data while req and addr stay unchanged.
- Combinational outputs:
  - imem_req = rst & (state==FETCH).
  - imem_addr = pc_out.
  - pc_plus2 = pc_out+16'd2, modulo 2^16 (FFFE -> 0000).
- instr_valid = (state==FETCH) & imem_rdy & ~stall & ~redirect & rst.
- FETCH, evaluated in priority order:
  1. redirect=1: pc <= {redirect_pc[15:1],1'b0}. If imem_rdy=1, stay FETCH (returned word squashed). If imem_rdy=0, go to DRAIN (outstanding fetch must be discarded).
  2. instr_valid=1 and hlt_req=1: go to HALTED; pc holds at the HLT address.
  3. instr_valid=1: pc <= pc+2.
  4. Otherwise (stall, or imem_rdy=0): pc holds and imem_req stays 1.
- DRAIN:
  - imem_req=0, instr_valid=0; redirect, stall and hlt_req are ignored.
  - Go to FETCH in the cycle after imem_rdy=1 is seen, with the new pc.
- HALTED:
  - halted=1, imem_req=0, instr_valid=0, pc holds.
  - All inputs ignored; only reset exits.
- Latency: sequential fetch with imem_rdy tied 1 and stall=0 accepts one instruction per cycle.
- Redirect-to-first-fetch latency: 1 cycle if imem_rdy was high at the redirect, otherwise the drain time + 1.
- Simultaneous events:
  - redirect together with hlt_req: redirect wins, HLT is squashed.
  - stall together with hlt_req: not accepted; HLT waits for stall=0.
  - Redirect to the current pc is legal and still squashes the fetch.

Optional Feature:
- Macro: PC_FETCH_CTRL_PERF_EN.
- Defined: adds output stall_cycles[15:0] and output drain_cycles[15:0].
  - stall_cycles increments each FETCH cycle with imem_req=1 and instr_valid=0 and redirect=0.
  - drain_cycles increments each DRAIN cycle.
  - Both saturate at 16'hFFFF, clear to 0 on reset, and freeze in HALTED.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch: rst=0 one cycle then 1, imem_rdy=1, stall=0 -> pc_out 0000,0002,0004,0006 on consecutive cycles; instr_valid=1 each cycle.
- Stall: stall=1 for 3 cycles at pc=0006 -> pc_out holds 0006, instr_valid=0, imem_req=1; stall=0 -> pc 0008 next cycle.
- Redirect with drain: at pc=0008 with imem_rdy=0, redirect=1, redirect_pc=0x1235 -> pc_out=1234, state DRAIN, imem_req=0. When imem_rdy=1 pulses, the next cycle has imem_req=1, imem_addr=1234, and that returned word is not accepted (instr_valid=0).
- Wrap and pc_plus2: redirect to FFFE, accept -> pc_out 0000, pc_plus2 0002.
- Halt: accept with hlt_req=1 at pc=0010 -> halted=1, pc_out stays 0010, imem_req=0 for 20 cycles despite redirect/stall toggling. Then rst=0 -> pc_out=0000, halted=0.
- Perf (PC_FETCH_CTRL_PERF_EN): 5 imem_rdy=0 cycles in FETCH -> stall_cycles=5. Then a 2-cycle drain -> drain_cycles=2. Reset -> both 0.
